// File: rtl/fifo_pkg.sv
// Shared constants and width helper for the single-clock FIFO family.
package fifo_pkg;

  localparam int FIFO_NORMAL    = 0;
  localparam int FIFO_SHOWAHEAD = 1;

  function automatic int fifo_clog2(input int unsigned value);
    int result;
    result = 0;
    for (int unsigned v = 1; v < value; v = v << 1) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/ram1r1w_param.sv
// Simple dual-port storage: one write port, one registered read port.
module ram1r1w_param
  import fifo_pkg::*;
#(
  parameter  int DATA_WIDTH = 64,
  parameter  int DEPTH      = 128,
  localparam int AW         = fifo_clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Only the read register is reset so the FIFO output reads zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fifo1c_param.sv
// Single-clock FIFO controller: pointers, occupancy, status flags, peak
// watermark and the optional show-ahead output stage around ram1r1w_param.
module fifo1c_param
  import fifo_pkg::*;
#(
  parameter  int DATA_WIDTH = 64,
  parameter  int DEPTH      = 128,
  parameter  int AFUL_THRES = DEPTH - 2,
  parameter  int AEMP_THRES = 1,
  parameter  int SHOWAHEAD  = FIFO_NORMAL,
  localparam int AW         = fifo_clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  wrreq,
  input  logic                  rdreq,
  input  logic                  flush,
  input  logic                  highest_clr,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [AW:0]           usedw,
  output logic [AW:0]           highest_dw,
  output logic                  overflow,
  output logic                  underflow
);

  typedef logic [AW:0]   cnt_t;
  typedef logic [AW-1:0] ptr_t;

  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);
  localparam cnt_t AFUL_C  = cnt_t'(AFUL_THRES);
  localparam cnt_t AEMP_C  = cnt_t'(AEMP_THRES);
  localparam bit   FWFT    = (SHOWAHEAD == FIFO_SHOWAHEAD);

  ptr_t wr_ptr;
  ptr_t rd_ptr;
  cnt_t count;
  cnt_t count_nxt;
  logic q_valid;
  logic q_valid_nxt;
  logic empty_i;
  logic full_i;
  logic wr_acc;
  logic rd_acc;
  logic fetch;
  logic ram_rd_en;

  assign full_i  = (count == DEPTH_C);
  assign empty_i = FWFT ? !q_valid : (count == '0);
  assign wr_acc  = wrreq && !full_i && !flush;
  assign rd_acc  = rdreq && !empty_i && !flush;

  // In show-ahead mode count includes the word parked in the output register,
  // so words still waiting in RAM are count - q_valid.
  assign fetch = !flush && (count != cnt_t'(q_valid)) && (!q_valid || rd_acc);

  always_comb begin
    ram_rd_en   = rd_acc;
    q_valid_nxt = 1'b0;
    if (FWFT) begin
      ram_rd_en = fetch;
      if (flush) begin
        q_valid_nxt = 1'b0;
      end else if (fetch) begin
        q_valid_nxt = 1'b1;
      end else if (rd_acc) begin
        q_valid_nxt = 1'b0;
      end else begin
        q_valid_nxt = q_valid;
      end
    end
  end

  always_comb begin
    count_nxt = count;
    if (flush) begin
      count_nxt = '0;
    end else if (wr_acc && !rd_acc) begin
      count_nxt = count + cnt_t'(1);
    end else if (!wr_acc && rd_acc) begin
      count_nxt = count - cnt_t'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      q_valid <= 1'b0;
    end else begin
      count   <= count_nxt;
      q_valid <= q_valid_nxt;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_acc) begin
          wr_ptr <= wr_ptr + ptr_t'(1);
        end
        if (ram_rd_en) begin
          rd_ptr <= rd_ptr + ptr_t'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      highest_dw   <= '0;
    end else begin
      almost_full  <= (count_nxt >= AFUL_C);
      almost_empty <= (count_nxt <= AEMP_C);
      overflow     <= wrreq && full_i && !flush;
      underflow    <= rdreq && empty_i && !flush;
      // A clear re-arms from the post-update occupancy, not the stale one.
      if (highest_clr || (count_nxt > highest_dw)) begin
        highest_dw <= count_nxt;
      end
    end
  end

  assign usedw = count;
  assign empty = empty_i;
  assign full  = full_i;

  ram1r1w_param #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_acc),
    .wr_addr(wr_ptr),
    .wr_data(data),
    .rd_en  (ram_rd_en),
    .rd_addr(rd_ptr),
    .rd_data(q)
  );

endmodule

// File: tb/tb_fifo1c_param.sv
// Directed bench for fifo1c_param: normal 128-deep, show-ahead 16-deep and a
// 16-deep normal instance exercised with a queue scoreboard across wraps.
module tb_fifo1c_param;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  logic [63:0] n_data = '0;
  logic        n_wr = 1'b0, n_rd = 1'b0, n_flush = 1'b0, n_hclr = 1'b0;
  logic [63:0] n_q;
  logic        n_empty, n_full, n_ae, n_af, n_ovf, n_udf;
  logic [7:0]  n_usedw, n_hdw;

  logic [7:0]  s_data = '0;
  logic        s_wr = 1'b0, s_rd = 1'b0, s_flush = 1'b0, s_hclr = 1'b0;
  logic [7:0]  s_q;
  logic        s_empty, s_full, s_ae, s_af, s_ovf, s_udf;
  logic [4:0]  s_usedw, s_hdw;

  logic [7:0]  r_data = '0;
  logic        r_wr = 1'b0, r_rd = 1'b0, r_flush = 1'b0, r_hclr = 1'b0;
  logic [7:0]  r_q;
  logic        r_empty, r_full, r_ae, r_af, r_ovf, r_udf;
  logic [4:0]  r_usedw, r_hdw;

  fifo1c_param #(.DATA_WIDTH(64), .DEPTH(128)) u_n (
    .clk(clk), .rst(rst), .data(n_data), .wrreq(n_wr), .rdreq(n_rd),
    .flush(n_flush), .highest_clr(n_hclr), .q(n_q), .empty(n_empty),
    .full(n_full), .almost_empty(n_ae), .almost_full(n_af), .usedw(n_usedw),
    .highest_dw(n_hdw), .overflow(n_ovf), .underflow(n_udf)
  );

  fifo1c_param #(.DATA_WIDTH(8), .DEPTH(16), .SHOWAHEAD(1)) u_s (
    .clk(clk), .rst(rst), .data(s_data), .wrreq(s_wr), .rdreq(s_rd),
    .flush(s_flush), .highest_clr(s_hclr), .q(s_q), .empty(s_empty),
    .full(s_full), .almost_empty(s_ae), .almost_full(s_af), .usedw(s_usedw),
    .highest_dw(s_hdw), .overflow(s_ovf), .underflow(s_udf)
  );

  fifo1c_param #(.DATA_WIDTH(8), .DEPTH(16), .AFUL_THRES(14), .AEMP_THRES(1)) u_r (
    .clk(clk), .rst(rst), .data(r_data), .wrreq(r_wr), .rdreq(r_rd),
    .flush(r_flush), .highest_clr(r_hclr), .q(r_q), .empty(r_empty),
    .full(r_full), .almost_empty(r_ae), .almost_full(r_af), .usedw(r_usedw),
    .highest_dw(r_hdw), .overflow(r_ovf), .underflow(r_udf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    n_vec++;
    if ({n_usedw, n_hdw, n_empty, n_ae, n_full, n_af, n_ovf, n_udf, n_q} !==
        {8'd0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0}) begin
      n_err++;
      $display("FAIL reset_n: got usedw=%0d hdw=%0d e=%b ae=%b f=%b af=%b ov=%b un=%b q=%h expected 0 0 1 1 0 0 0 0 0",
               n_usedw, n_hdw, n_empty, n_ae, n_full, n_af, n_ovf, n_udf, n_q);
    end
    n_vec++;
    if ({s_usedw, s_hdw, s_empty, s_ae, s_full, s_af, s_ovf, s_udf, s_q,
         r_usedw, r_hdw, r_empty, r_ae, r_full, r_af, r_ovf, r_udf, r_q} !==
        {5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,
         5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0}) begin
      n_err++;
      $display("FAIL reset_s_r: got s usedw=%0d e=%b q=%h r usedw=%0d e=%b q=%h expected all reset values",
               s_usedw, s_empty, s_q, r_usedw, r_empty, r_q);
    end
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_fill();
    n_wr = 1'b1;
    for (int i = 0; i < 128; i++) begin
      n_data = 64'(i);
      tick();
      n_vec++;
      if ({n_usedw, n_empty, n_full, n_af, n_ae, n_ovf} !==
          {8'(i + 1), 1'b0, (i == 127), (i + 1 >= 126), (i + 1 <= 1), 1'b0}) begin
        n_err++;
        $display("FAIL fill_step %0d: got usedw=%0d e=%b f=%b af=%b ae=%b ov=%b expected usedw=%0d",
                 i, n_usedw, n_empty, n_full, n_af, n_ae, n_ovf, i + 1);
      end
    end
    n_data = 64'hDEAD;
    tick();
    n_wr = 1'b0;
    n_vec++;
    if ({n_usedw, n_full, n_ovf} !== {8'd128, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL fill_overflow: got usedw=%0d f=%b ov=%b expected 128 1 1", n_usedw, n_full, n_ovf);
    end
    tick();
    n_vec++;
    if ({n_usedw, n_ovf, n_hdw} !== {8'd128, 1'b0, 8'd128}) begin
      n_err++;
      $display("FAIL fill_ovf_once: got usedw=%0d ov=%b hdw=%0d expected 128 0 128", n_usedw, n_ovf, n_hdw);
    end
  endtask

  task automatic test_drain();
    n_rd = 1'b1;
    for (int i = 0; i < 128; i++) begin
      tick();
      n_vec++;
      if ({n_q, n_usedw, n_empty, n_udf} !== {64'(i), 8'(127 - i), (i == 127), 1'b0}) begin
        n_err++;
        $display("FAIL drain_step %0d: got q=%0d usedw=%0d e=%b un=%b expected q=%0d usedw=%0d",
                 i, n_q, n_usedw, n_empty, n_udf, i, 127 - i);
      end
    end
    tick();
    n_rd = 1'b0;
    n_vec++;
    if ({n_udf, n_usedw, n_q} !== {1'b1, 8'd0, 64'd127}) begin
      n_err++;
      $display("FAIL drain_underflow: got un=%b usedw=%0d q=%0d expected 1 0 127", n_udf, n_usedw, n_q);
    end
    tick();
    n_vec++;
    if ({n_udf, n_usedw} !== {1'b0, 8'd0}) begin
      n_err++;
      $display("FAIL drain_udf_once: got un=%b usedw=%0d expected 0 0", n_udf, n_usedw);
    end
  endtask

  task automatic test_concurrent();
    n_wr = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_data = 64'(10 + k);
      tick();
    end
    n_rd = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_data = 64'(13 + k);
      tick();
      n_vec++;
      if ({n_usedw, n_q} !== {8'd3, 64'(10 + k)}) begin
        n_err++;
        $display("FAIL concurrent_rw %0d: got usedw=%0d q=%0d expected 3 %0d", k, n_usedw, n_q, 10 + k);
      end
    end
    n_wr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_vec++;
      if ({n_usedw, n_q} !== {8'(2 - k), 64'(13 + k)}) begin
        n_err++;
        $display("FAIL concurrent_drain %0d: got usedw=%0d q=%0d expected %0d %0d", k, n_usedw, n_q, 2 - k, 13 + k);
      end
    end
    n_rd = 1'b0;
  endtask

  task automatic test_flush();
    n_hclr = 1'b1;
    tick();
    n_hclr = 1'b0;
    n_vec++;
    if (n_hdw !== 8'd0) begin
      n_err++;
      $display("FAIL flush_pre_clr: got hdw=%0d expected 0", n_hdw);
    end
    n_wr = 1'b1;
    for (int k = 0; k < 100; k++) begin
      n_data = 64'(1000 + k);
      tick();
    end
    n_vec++;
    if ({n_usedw, n_hdw} !== {8'd100, 8'd100}) begin
      n_err++;
      $display("FAIL flush_fill100: got usedw=%0d hdw=%0d expected 100 100", n_usedw, n_hdw);
    end
    n_flush = 1'b1;
    n_data = 64'hFF;
    tick();
    n_flush = 1'b0;
    n_wr = 1'b0;
    n_vec++;
    if ({n_usedw, n_empty, n_full, n_ovf, n_udf, n_ae, n_hdw, n_q} !==
        {8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd100, 64'd15}) begin
      n_err++;
      $display("FAIL flush_result: got usedw=%0d e=%b f=%b ov=%b un=%b ae=%b hdw=%0d q=%0d expected 0 1 0 0 0 1 100 15",
               n_usedw, n_empty, n_full, n_ovf, n_udf, n_ae, n_hdw, n_q);
    end
    n_hclr = 1'b1;
    tick();
    n_vec++;
    if (n_hdw !== 8'd0) begin
      n_err++;
      $display("FAIL flush_hclr: got hdw=%0d expected 0", n_hdw);
    end
    n_wr = 1'b1;
    n_data = 64'h77;
    tick();
    n_wr = 1'b0;
    n_hclr = 1'b0;
    n_vec++;
    if ({n_hdw, n_usedw} !== {8'd1, 8'd1}) begin
      n_err++;
      $display("FAIL hclr_with_write: got hdw=%0d usedw=%0d expected 1 1", n_hdw, n_usedw);
    end
    n_rd = 1'b1;
    tick();
    n_rd = 1'b0;
    n_vec++;
    if ({n_q, n_usedw} !== {64'h77, 8'd0}) begin
      n_err++;
      $display("FAIL flush_ptr_reuse: got q=%h usedw=%0d expected 77 0", n_q, n_usedw);
    end
  endtask

  task automatic test_rst_mid();
    n_wr = 1'b1;
    for (int k = 0; k < 50; k++) begin
      n_data = 64'(200 + k);
      tick();
    end
    n_wr = 1'b0;
    n_vec++;
    if (n_usedw !== 8'd50) begin
      n_err++;
      $display("FAIL rstmid_fill50: got usedw=%0d expected 50", n_usedw);
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({n_usedw, n_hdw, n_empty, n_ae, n_full, n_af, n_ovf, n_udf, n_q} !==
        {8'd0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0}) begin
      n_err++;
      $display("FAIL rstmid_async: got usedw=%0d hdw=%0d e=%b ae=%b f=%b af=%b q=%h expected reset values",
               n_usedw, n_hdw, n_empty, n_ae, n_full, n_af, n_q);
    end
    tick();
    rst = 1'b0;
    n_wr = 1'b1;
    n_data = 64'h3C;
    tick();
    n_wr = 1'b0;
    n_vec++;
    if ({n_usedw, n_empty} !== {8'd1, 1'b0}) begin
      n_err++;
      $display("FAIL rstmid_write: got usedw=%0d e=%b expected 1 0", n_usedw, n_empty);
    end
    n_rd = 1'b1;
    tick();
    n_rd = 1'b0;
    n_vec++;
    if ({n_q, n_usedw, n_empty} !== {64'h3C, 8'd0, 1'b1}) begin
      n_err++;
      $display("FAIL rstmid_read: got q=%h usedw=%0d e=%b expected 3c 0 1", n_q, n_usedw, n_empty);
    end
  endtask

  task automatic test_showahead();
    s_data = 8'hA5;
    s_wr = 1'b1;
    tick();
    s_wr = 1'b0;
    n_vec++;
    if ({s_empty, s_usedw} !== {1'b1, 5'd1}) begin
      n_err++;
      $display("FAIL sa_empty_lat1: got e=%b usedw=%0d expected 1 1", s_empty, s_usedw);
    end
    tick();
    n_vec++;
    if ({s_empty, s_q, s_usedw} !== {1'b0, 8'hA5, 5'd1}) begin
      n_err++;
      $display("FAIL sa_empty_lat2: got e=%b q=%h usedw=%0d expected 0 a5 1", s_empty, s_q, s_usedw);
    end
    s_rd = 1'b1;
    tick();
    s_rd = 1'b0;
    n_vec++;
    if ({s_empty, s_usedw, s_udf} !== {1'b1, 5'd0, 1'b0}) begin
      n_err++;
      $display("FAIL sa_pop_single: got e=%b usedw=%0d un=%b expected 1 0 0", s_empty, s_usedw, s_udf);
    end
    s_wr = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      s_data = 8'(k);
      tick();
    end
    s_wr = 1'b0;
    n_vec++;
    if ({s_empty, s_q, s_usedw} !== {1'b0, 8'd1, 5'd4}) begin
      n_err++;
      $display("FAIL sa_burst_head: got e=%b q=%0d usedw=%0d expected 0 1 4", s_empty, s_q, s_usedw);
    end
    s_rd = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_vec++;
      if ({s_empty, s_q, s_usedw} !== {1'b0, 8'(k + 1), 5'(4 - k)}) begin
        n_err++;
        $display("FAIL sa_burst_pop %0d: got e=%b q=%0d usedw=%0d expected 0 %0d %0d",
                 k, s_empty, s_q, s_usedw, k + 1, 4 - k);
      end
    end
    tick();
    n_vec++;
    if ({s_empty, s_usedw} !== {1'b1, 5'd0}) begin
      n_err++;
      $display("FAIL sa_burst_last: got e=%b usedw=%0d expected 1 0", s_empty, s_usedw);
    end
    tick();
    s_rd = 1'b0;
    n_vec++;
    if ({s_udf, s_empty, s_usedw} !== {1'b1, 1'b1, 5'd0}) begin
      n_err++;
      $display("FAIL sa_underflow: got un=%b e=%b usedw=%0d expected 1 1 0", s_udf, s_empty, s_usedw);
    end
    s_wr = 1'b1;
    for (int k = 0; k < 16; k++) begin
      s_data = 8'(8'h80 + k);
      tick();
    end
    n_vec++;
    if ({s_full, s_usedw, s_q, s_empty, s_af, s_udf} !== {1'b1, 5'd16, 8'h80, 1'b0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL sa_full: got f=%b usedw=%0d q=%h e=%b af=%b expected 1 16 80 0 1", s_full, s_usedw, s_q, s_empty, s_af);
    end
    s_data = 8'hFF;
    tick();
    s_wr = 1'b0;
    n_vec++;
    if ({s_ovf, s_usedw, s_full} !== {1'b1, 5'd16, 1'b1}) begin
      n_err++;
      $display("FAIL sa_overflow: got ov=%b usedw=%0d f=%b expected 1 16 1", s_ovf, s_usedw, s_full);
    end
    s_rd = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      n_vec++;
      if ({s_q, s_empty, s_usedw} !== {8'(8'h80 + k), 1'b0, 5'(16 - k)}) begin
        n_err++;
        $display("FAIL sa_wrap_pop %0d: got q=%h e=%b usedw=%0d expected %h 0 %0d",
                 k, s_q, s_empty, s_usedw, 8'h80 + k, 16 - k);
      end
    end
    tick();
    s_rd = 1'b0;
    n_vec++;
    if ({s_empty, s_usedw} !== {1'b1, 5'd0}) begin
      n_err++;
      $display("FAIL sa_wrap_empty: got e=%b usedw=%0d expected 1 0", s_empty, s_usedw);
    end
  endtask

  task automatic test_full_rw();
    r_wr = 1'b1;
    for (int k = 0; k < 16; k++) begin
      r_data = 8'(8'h40 + k);
      tick();
    end
    r_wr = 1'b0;
    n_vec++;
    if ({r_full, r_usedw, r_af, r_ae} !== {1'b1, 5'd16, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL r_full: got f=%b usedw=%0d af=%b ae=%b expected 1 16 1 0", r_full, r_usedw, r_af, r_ae);
    end
    r_wr = 1'b1;
    r_rd = 1'b1;
    r_data = 8'hEE;
    tick();
    r_wr = 1'b0;
    r_rd = 1'b0;
    n_vec++;
    if ({r_full, r_usedw, r_ovf, r_q} !== {1'b0, 5'd15, 1'b1, 8'h40}) begin
      n_err++;
      $display("FAIL r_full_rw: got f=%b usedw=%0d ov=%b q=%h expected 0 15 1 40", r_full, r_usedw, r_ovf, r_q);
    end
  endtask

  task automatic test_random();
    logic [7:0] sb[$];
    logic [7:0] exp_q;
    logic [7:0] d;
    logic       w, r, f_e, e_e, exp_ovf, exp_udf;
    logic [4:0] exp_cnt;
    int         wp;
    exp_q = 8'h40;
    for (int k = 1; k < 16; k++) sb.push_back(8'(8'h40 + k));
    for (int c = 0; c < 1000; c++) begin
      wp = (((c / 50) % 2) == 0) ? 70 : 30;
      w = (int'($urandom_range(99)) < wp);
      r = (int'($urandom_range(99)) < (100 - wp));
      d = 8'($urandom);
      e_e = (sb.size() == 0);
      f_e = (sb.size() == 16);
      exp_ovf = w && f_e;
      exp_udf = r && e_e;
      if (r && !e_e) exp_q = sb.pop_front();
      if (w && !f_e) sb.push_back(d);
      exp_cnt = 5'(sb.size());
      r_data = d;
      r_wr = w;
      r_rd = r;
      tick();
      n_vec++;
      if ({r_q, r_usedw, r_full, r_empty, r_af, r_ae, r_ovf, r_udf} !==
          {exp_q, exp_cnt, (exp_cnt == 5'd16), (exp_cnt == 5'd0), (exp_cnt >= 5'd14),
           (exp_cnt <= 5'd1), exp_ovf, exp_udf}) begin
        n_err++;
        $display("FAIL rand_cycle %0d: got q=%h usedw=%0d f=%b e=%b af=%b ae=%b ov=%b un=%b expected q=%h usedw=%0d ov=%b un=%b",
                 c, r_q, r_usedw, r_full, r_empty, r_af, r_ae, r_ovf, r_udf, exp_q, exp_cnt, exp_ovf, exp_udf);
      end
    end
    r_wr = 1'b0;
    r_rd = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_concurrent();
    test_flush();
    test_rst_mid();
    test_showahead();
    test_full_rw();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo1c_param.md
FIFO1C_PARAM -- requirements
Module: fifo1c_param

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-002 Parameter DATA_WIDTH, default 64, SHALL set the word width.
REQ-003 Parameter DEPTH, default 128, SHALL set the word count; it is a power of two, >=4.
REQ-004 Parameter AFUL_THRES, default DEPTH-2, SHALL set the almost_full threshold.
REQ-005 Parameter AEMP_THRES, default 1, SHALL set the almost_empty threshold.
REQ-006 Parameter SHOWAHEAD, default 0, SHALL select normal (0) or first-word-fall-through (1) read mode.
REQ-007 Derived constant AW = clog2(DEPTH); the count width is AW+1.
REQ-008 Ports SHALL be:
- clk  in  1  clock
- rst  in  1  async reset, active-high
- data  in  DATA_WIDTH  write data
- wrreq  in  1  write request
- rdreq  in  1  read request/pop
- flush  in  1  synchronous clear of contents
- highest_clr  in  1  re-arm watermark
- q  out  DATA_WIDTH  read data
- empty / full  out  1  status
- almost_empty / almost_full  out  1  threshold status
- usedw  out  AW+1  occupancy
- highest_dw  out  AW+1  peak occupancy
- overflow / underflow  out  1  single-cycle error pulses

Function
REQ-009 A write SHALL be accepted when wrreq=1 and full=0; when full=1, the write SHALL be dropped and overflow SHALL pulse the next cycle.
REQ-010 A read SHALL be accepted when rdreq=1 and empty=0; when empty=1, memory SHALL be unchanged and underflow SHALL pulse the next cycle.
REQ-011 When full=1, a simultaneous wrreq and rdreq SHALL accept the read, drop the write and pulse overflow.
REQ-012 When not full and not empty, a simultaneous accepted read and write SHALL leave usedw unchanged.
REQ-013 In SHOWAHEAD=0 mode, q SHALL present the popped word one cycle after an accepted rdreq and hold it until the next accepted read.
REQ-014 In SHOWAHEAD=1 mode, q SHALL present the head word whenever empty=0.
- empty SHALL deassert 2 cycles after a write into an empty FIFO.
- An accepted rdreq SHALL advance q to the next word on the following cycle.
REQ-015 usedw SHALL update the cycle after each accepted operation and range 0..DEPTH.
- full = (usedw==DEPTH).
- empty = (usedw==0) in normal mode; in SHOWAHEAD mode, empty = !q_valid.
REQ-016 almost_full SHALL equal (usedw>=AFUL_THRES), and almost_empty SHALL equal (usedw<=AEMP_THRES), both registered.
REQ-017 Pointers SHALL wrap modulo DEPTH with no lost words at the wrap boundary.
REQ-018 flush SHALL have priority over wrreq and rdreq.
- Next cycle: pointers=0, usedw=0, empty=1, full=0, no overflow/underflow pulse.
- q and highest_dw SHALL be unchanged.
REQ-019 highest_dw SHALL track max(usedw).
- When highest_clr=1, highest_dw SHALL load the current usedw next cycle.
- When highest_clr coincides with a usedw change, the new usedw SHALL be taken.

Reset
REQ-020 While rst=1, the block SHALL force: pointers=0, usedw=0, highest_dw=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, q=0.
REQ-021 Assertion of rst mid-operation SHALL discard all contents immediately, and the first write after deassertion SHALL behave as a write into an empty FIFO.

Structure
REQ-022 Controller logic (pointers, counters, flags, SHOWAHEAD output stage) SHALL be in fifo1c_param.
REQ-023 Storage SHALL be the single sub-module ram1r1w_param (DATA_WIDTH x DEPTH, registered read, one write port, one read port), with no read-during-write bypass required.
REQ-024 Shared package fifo_pkg SHALL hold the clog2-based width function and the mode constants FIFO_NORMAL=0 and FIFO_SHOWAHEAD=1.

Verification
REQ-025 DEPTH=128, normal mode: write 128 words 0..127 -> full=1 and usedw=128; a 129th write -> overflow pulses once and usedw stays 128.
REQ-026 Normal mode: read all 128 words -> q=0..127 in order, each one cycle after rdreq; then one extra rdreq -> underflow pulses once and usedw=0.
REQ-027 SHOWAHEAD=1: single write of 0xA5 -> empty=0 two cycles later with q=0xA5 before any rdreq; rdreq -> empty=1 next cycle.
REQ-028 Fill to 100, assert flush together with wrreq -> usedw=0 and empty=1 next cycle; highest_dw=100; highest_clr -> highest_dw=0.
REQ-029 Run 1000 cycles of random concurrent read/write across pointer wrap with DEPTH=16 and DATA_WIDTH=8 -> scoreboard matches, and almost_full at usedw>=14 and almost_empty at usedw<=1 are correct every cycle.
REQ-030 Assert rst while usedw=50 -> all outputs reach their reset values with no clock edge required; after release, write 0x3C and read it -> q=0x3C.
